// File: rtl/aes_ks_pkg.sv
// Shared constants, types and helpers for the AES-256 round key store.
package aes_ks_pkg;

  localparam int KEY_W     = 256;
  localparam int RK_W      = 128;
  localparam int NUM_RK    = 15;
  localparam int NUM_WORDS = 8;
  localparam int WAIT_MAX  = 4;
  localparam int IDX_W     = 4;
  localparam int WORD_W    = $clog2(NUM_WORDS);
  localparam int CNT_W     = WORD_W;

  typedef logic [RK_W-1:0] rk_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_CAPTURE,
    ST_READY
  } ksState_t;

  // Decrypt order walks the key set backwards from RK14.
  function automatic logic [IDX_W-1:0] physIdx(input logic dir, input logic [IDX_W-1:0] idx);
    return dir ? (IDX_W'(NUM_RK - 1) - idx) : idx;
  endfunction

endpackage

// File: rtl/aes_rk_regfile.sv
// 15 x 128 round key register file: two keys written per schedule word,
// one registered read with direction mapping and out-of-range-to-zero.
module aes_rk_regfile
  import aes_ks_pkg::*;
(
  input  logic              inClk,
  input  logic              inRstN,
  input  logic              wrEn,
  input  logic [WORD_W-1:0] wrWord,
  input  logic [KEY_W-1:0]  wrData,
  input  logic              rdDir,
  input  logic [IDX_W-1:0]  rdIdx,
  output rk_t               rdKey
);

  rk_t rkReg [NUM_RK];

  // Word w fills RK(2w) from the high half and RK(2w+1) from the low half;
  // the last word's low half has no slot and is dropped.
  always_ff @(posedge inClk) begin
    if (!inRstN) begin
      for (int i = 0; i < NUM_RK; i++) rkReg[i] <= '0;
    end else if (wrEn) begin
      rkReg[{wrWord, 1'b0}] <= wrData[KEY_W-1 -: RK_W];
      if (wrWord != WORD_W'(NUM_WORDS - 1))
        rkReg[{wrWord, 1'b1}] <= wrData[RK_W-1:0];
    end
  end

  // Registered read; indices past RK14 return zero rather than stale data.
  always_ff @(posedge inClk) begin
    if (!inRstN)
      rdKey <= '0;
    else if (rdIdx > IDX_W'(NUM_RK - 1))
      rdKey <= '0;
    else
      rdKey <= rkReg[physIdx(rdDir, rdIdx)];
  end

endmodule

// File: rtl/aes_round_key_store.sv
// Collects the AES-256 key schedule output stream into 15 round keys and
// serves them to the round datapath in encrypt or decrypt order.
module aes_round_key_store
  import aes_ks_pkg::*;
(
  input  logic             inClk,
  input  logic             inRstN,
  input  logic             inLoad,
  input  logic [KEY_W-1:0] inKey,
  output logic             outKsWr,
  output logic [KEY_W-1:0] outKsKey,
  input  logic [KEY_W-1:0] inKsRoundKey,
  input  logic             inKsBusy,
  input  logic             inRdDir,
  input  logic [IDX_W-1:0] inRdIdx,
  output logic [RK_W-1:0]  outRdKey,
  output logic             outReady,
  output logic             outBusy,
  output logic             outError
);

  ksState_t          state, nxtState;
  logic [CNT_W-1:0]  cnt, nxtCnt;
  logic              errFlag, nxtErr;
  logic              latchKey;
  logic              wrEn;
  logic [WORD_W-1:0] wrWord;
  logic [KEY_W-1:0]  ksKey;

  // State, counter, error flag and key copy registers.
  always_ff @(posedge inClk) begin
    if (!inRstN) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      errFlag <= 1'b0;
      ksKey   <= '0;
    end else begin
      state   <= nxtState;
      cnt     <= nxtCnt;
      errFlag <= nxtErr;
      if (latchKey) ksKey <= inKey;
    end
  end

  // Next-state logic. In START/WAIT the counter counts cycles since the
  // strobe, so the timeout lands WAIT_MAX cycles after outKsWr. In CAPTURE
  // it is the index of the word being stored.
  always_comb begin
    nxtState = state;
    nxtCnt   = cnt;
    nxtErr   = errFlag;
    latchKey = 1'b0;
    wrEn     = 1'b0;
    wrWord   = cnt;
    case (state)
      ST_IDLE, ST_READY: begin
        if (inLoad) begin
          latchKey = 1'b1;
          nxtErr   = 1'b0;
          nxtCnt   = '0;
          nxtState = ST_START;
        end
      end
      ST_START: begin
        nxtCnt   = cnt + 1'b1;
        nxtState = ST_WAIT;
      end
      ST_WAIT: begin
        if (inKsBusy) begin
          wrEn     = 1'b1;
          wrWord   = '0;
          nxtCnt   = CNT_W'(1);
          nxtState = ST_CAPTURE;
        end else if (cnt == CNT_W'(WAIT_MAX - 1)) begin
          nxtErr   = 1'b1;
          nxtCnt   = '0;
          nxtState = ST_IDLE;
        end else begin
          nxtCnt = cnt + 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (inKsBusy) begin
          wrEn   = 1'b1;
          nxtCnt = cnt + 1'b1;
          if (cnt == CNT_W'(NUM_WORDS - 1)) nxtState = ST_READY;
        end else begin
          nxtErr   = 1'b1;
          nxtCnt   = '0;
          nxtState = ST_IDLE;
        end
      end
      default: nxtState = ST_IDLE;
    endcase
  end

  assign outKsWr  = (state == ST_START);
  assign outBusy  = (state == ST_START) || (state == ST_WAIT) || (state == ST_CAPTURE);
  assign outReady = (state == ST_READY);
  assign outError = errFlag;
  assign outKsKey = ksKey;

  aes_rk_regfile uRegfile (
    .inClk  (inClk),
    .inRstN (inRstN),
    .wrEn   (wrEn),
    .wrWord (wrWord),
    .wrData (inKsRoundKey),
    .rdDir  (inRdDir),
    .rdIdx  (inRdIdx),
    .rdKey  (outRdKey)
  );

endmodule
